dpram_arbiter: RTL

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

---
 rtl/dpram_arb_pkg.sv | 20 ++
 rtl/dpram_arbiter_if.sv | 41 ++++
 rtl/rr_pick.sv | 30 +++
 rtl/dpram_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared sizing defaults, client-index width and the per-port grant tag record
// for the dual-port RAM arbiter.
package dpram_arb_pkg;

    localparam int NC_DEF = 4;
    localparam int AW_DEF = 6;
    localparam int DW_DEF = 8;
    localparam int CIW    = $clog2(NC_DEF);

    typedef struct packed {
        logic           vld;
        logic [CIW-1:0] idx;
        logic           rd;
    } port_tag_t;

    function automatic logic [CIW-1:0] wrap_inc(input logic [CIW-1:0] i, input int n);
        return CIW'((int'(i) + 1) % n);
    endfunction

endpackage

// File: rtl/dpram_arbiter_if.sv
// Client request/response bus plus the two RAM port drives of the arbiter.
interface dpram_arbiter_if
    import dpram_arb_pkg::*;
#(
    parameter int NC = NC_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic [NC-1:0]    req;
    logic [NC-1:0]    we;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [NC-1:0]    gnt;
    logic [NC-1:0]    rvalid;
    logic [NC*DW-1:0] rdata;

    logic [DW-1:0]    ram_data_a;
    logic [AW-1:0]    ram_addr_a;
    logic             ram_we_a;
    logic [DW-1:0]    ram_data_b;
    logic [AW-1:0]    ram_addr_b;
    logic             ram_we_b;
    logic [DW-1:0]    ram_q_a;
    logic [DW-1:0]    ram_q_b;

    modport master (
        output req, we, addr, wdata, ram_q_a, ram_q_b,
        input  gnt, rvalid, rdata,
        input  ram_data_a, ram_addr_a, ram_we_a,
        input  ram_data_b, ram_addr_b, ram_we_b
    );

    modport slave (
        input  req, we, addr, wdata, ram_q_a, ram_q_b,
        output gnt, rvalid, rdata,
        output ram_data_a, ram_addr_a, ram_we_a,
        output ram_data_b, ram_addr_b, ram_we_b
    );

endinterface

// File: rtl/rr_pick.sv
// Cyclic find-first: lowest cyclic distance from start among set mask bits.
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int N = NC_DEF
)
(
    input  logic [CIW-1:0] start,
    input  logic [N-1:0]   mask,
    output logic           found,
    output logic [CIW-1:0] idx
);

    logic [CIW-1:0] cand;

    // Scan farthest-first so the nearest candidate overwrites the result last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = CIW'((int'(start) + k) % N);
            if (mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NC clients; port B takes
// the next non-conflicting requester after the port-A winner.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NC = NC_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)
(
    input  logic          clk,
    input  logic          rst,
    dpram_arbiter_if.slave bus
);

    logic [CIW-1:0]   ptr;
    logic [CIW-1:0]   a_idx;
    logic [CIW-1:0]   b_idx;
    logic [CIW-1:0]   b_start;
    logic             a_found;
    logic             b_found;
    logic             grant_a;
    logic             grant_b;
    logic [AW-1:0]    a_addr;
    logic             a_we;
    logic [NC-1:0]    mask_b;
    logic [NC-1:0]    rvalid_c;
    logic [NC*DW-1:0] rdata_c;
    logic [NC*DW-1:0] rdata_q;
    port_tag_t        tag_a_p1;
    port_tag_t        tag_b_p1;

    rr_pick #(.N(NC)) u_pick_a (
        .start (ptr),
        .mask  (bus.req),
        .found (a_found),
        .idx   (a_idx)
    );

    assign a_addr  = bus.addr[int'(a_idx)*AW +: AW];
    assign a_we    = bus.we[a_idx];
    assign b_start = wrap_inc(a_idx, NC);

    // Same address as the A winner with any write involved must wait a cycle.
    always_comb begin
        mask_b = bus.req;
        for (int i = 0; i < NC; i++) begin
            if ((bus.addr[i*AW +: AW] == a_addr) && (bus.we[i] || a_we))
                mask_b[i] = 1'b0;
        end
        mask_b[a_idx] = 1'b0;
    end

    rr_pick #(.N(NC)) u_pick_b (
        .start (b_start),
        .mask  (mask_b),
        .found (b_found),
        .idx   (b_idx)
    );

    assign grant_a = a_found & ~rst;
    assign grant_b = b_found & ~rst;

    always_comb begin
        bus.gnt        = '0;
        bus.ram_addr_a = '0;
        bus.ram_data_a = '0;
        bus.ram_we_a   = 1'b0;
        bus.ram_addr_b = '0;
        bus.ram_data_b = '0;
        bus.ram_we_b   = 1'b0;
        if (grant_a) begin
            bus.gnt[a_idx] = 1'b1;
            bus.ram_addr_a = a_addr;
            bus.ram_data_a = bus.wdata[int'(a_idx)*DW +: DW];
            bus.ram_we_a   = a_we;
        end
        if (grant_b) begin
            bus.gnt[b_idx] = 1'b1;
            bus.ram_addr_b = bus.addr[int'(b_idx)*AW +: AW];
            bus.ram_data_b = bus.wdata[int'(b_idx)*DW +: DW];
            bus.ram_we_b   = bus.we[b_idx];
        end
    end

    // p1: RAM output register is valid now; steer it to the tagged client.
    always_comb begin
        rvalid_c = '0;
        rdata_c  = rdata_q;
        if (tag_a_p1.vld && tag_a_p1.rd) begin
            rvalid_c[tag_a_p1.idx]                  = 1'b1;
            rdata_c[int'(tag_a_p1.idx)*DW +: DW]    = bus.ram_q_a;
        end
        if (tag_b_p1.vld && tag_b_p1.rd) begin
            rvalid_c[tag_b_p1.idx]                  = 1'b1;
            rdata_c[int'(tag_b_p1.idx)*DW +: DW]    = bus.ram_q_b;
        end
    end

    assign bus.rvalid = rvalid_c;
    assign bus.rdata  = rdata_c;

    // p0 -> p1: record grants and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            tag_a_p1 <= '0;
            tag_b_p1 <= '0;
            rdata_q  <= '0;
        end else begin
            if (grant_b)
                ptr <= wrap_inc(b_idx, NC);
            else if (grant_a)
                ptr <= wrap_inc(a_idx, NC);
            tag_a_p1 <= '{vld: grant_a, idx: a_idx, rd: ~a_we};
            tag_b_p1 <= '{vld: grant_b, idx: b_idx, rd: ~bus.we[b_idx]};
            rdata_q  <= rdata_c;
        end
    end

endmodule
